// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types for the instruction fetch controller:
// FSM encoding, prefetch entry layout and sequential-PC helper.
package inst_fetch_ctrl_pkg;

  localparam int          IFQ_DEPTH  = 4;
  localparam logic [31:0] INST_BYTES = 32'd4;

  typedef enum logic [1:0] {
    IF_FETCH = 2'd0,
    IF_WAIT  = 2'd1,
    IF_DRAIN = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] seq_pc(
    input logic [31:0] pc
  );
    return pc + INST_BYTES;
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// I-cache and decoder side signals of the fetch controller.
// master = fetch controller, slave = i-cache/decoder environment.
interface inst_fetch_ctrl_if;

  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_ack;
  logic [31:0] icache_inst;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_inst_addr;
  logic        start_decoder;
  logic        issue_signal;
  logic [31:0] next_pc;
  logic        wrong_predicted;
  logic [31:0] correct_pc;

  modport master (
    output icache_req,
    output icache_addr,
    input  icache_ack,
    input  icache_inst,
    output dec_valid,
    output dec_inst,
    output dec_inst_addr,
    output start_decoder,
    input  issue_signal,
    input  next_pc,
    input  wrong_predicted,
    input  correct_pc
  );

  modport slave (
    input  icache_req,
    input  icache_addr,
    output icache_ack,
    output icache_inst,
    input  dec_valid,
    input  dec_inst,
    input  dec_inst_addr,
    input  start_decoder,
    output issue_signal,
    output next_pc,
    output wrong_predicted,
    output correct_pc
  );

endinterface

// File: rtl/inst_fetch_ctrl_fifo.sv
// Prefetch FIFO: circular buffer of {addr, inst} entries.
// Clear wins over push/pop; en_in low freezes everything.
module inst_fetch_ctrl_fifo
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         en_in,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(DEPTH));
  assign head   = mem_q[rd_ptr_q];
  assign do_pop = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (en_in) begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: i-cache request FSM feeding a
// prefetch FIFO whose head is offered to the decoder.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int          QDEPTH   = IFQ_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic              clk_in,
  input logic              rst_in,
  input logic              rdy_in,
  inst_fetch_ctrl_if.master bus
);

  if_state_e    state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         req_q, req_d;

  fetch_entry_t head;
  fetch_entry_t wdata;
  logic         full, empty;
  logic         flush, pop, redirect, clear, push;
  logic [31:0]  target;

  // Flush outranks issue; a popped head whose successor is not
  // sequential restarts fetch at next_pc.
  assign flush    = bus.wrong_predicted;
  assign pop      = bus.issue_signal && !empty && !flush;
  assign redirect = pop && (bus.next_pc != seq_pc(head.addr));
  assign clear    = flush || redirect;
  assign target   = flush ? bus.correct_pc : bus.next_pc;
  assign push     = (state_q == IF_WAIT) && bus.icache_ack && !clear;
  assign wdata    = '{addr: fetch_pc_q, inst: bus.icache_inst};

  inst_fetch_ctrl_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .en_in  (rdy_in),
    .clear  (clear),
    .push   (push),
    .pop    (pop),
    .wdata  (wdata),
    .head   (head),
    .full   (full),
    .empty  (empty)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    unique case (state_q)
      IF_FETCH: begin
        if (clear) begin
          fetch_pc_d = target;
        end else if (!full) begin
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
          state_d = IF_WAIT;
        end
      end
      IF_WAIT: begin
        if (clear) begin
          fetch_pc_d = target;
          if (bus.icache_ack) begin
            req_d   = 1'b0;
            state_d = IF_FETCH;
          end else begin
            state_d = IF_DRAIN;
          end
        end else if (bus.icache_ack) begin
          fetch_pc_d = seq_pc(fetch_pc_q);
          req_d      = 1'b0;
          state_d    = IF_FETCH;
        end
      end
      IF_DRAIN: begin
        if (clear) begin
          fetch_pc_d = target;
        end
        if (bus.icache_ack) begin
          req_d   = 1'b0;
          state_d = IF_FETCH;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IF_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IF_FETCH;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
    end
  end

  assign bus.icache_req    = req_q;
  assign bus.icache_addr   = addr_q;
  assign bus.dec_valid     = !empty;
  assign bus.dec_inst      = head.inst;
  assign bus.dec_inst_addr = head.addr;
  assign bus.start_decoder = !empty && !bus.wrong_predicted;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Randomized scoreboard bench for inst_fetch_ctrl against a
// queue-based model of fetched-but-unissued instruction addresses.
module tb_inst_fetch_ctrl;

  localparam int QD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rdy   = 1'b1;

  inst_fetch_ctrl_if bus ();

  inst_fetch_ctrl #(
    .QDEPTH   (QD),
    .RESET_PC (32'h0)
  ) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .rdy_in (rdy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          errors  = 0;
  int          pops    = 0;
  int          ack_dly = 0;
  logic [31:0] buf_q[$];
  logic [31:0] fetch_ptr = 32'h0;
  bit          stale     = 1'b0;
  bit          prev_req  = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: advance the model with the inputs the DUT consumed at
  // this edge, then compare the DUT's new outputs with it.
  bit          has, pop_m, redir, cancel, acked;
  logic [31:0] tgt;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      buf_q.delete();
      fetch_ptr = 32'h0;
      stale     = 1'b0;
      prev_req  = 1'b0;
      prev_addr = 32'h0;
    end else begin
      acked = 1'b0;
      if (rdy) begin
        has    = buf_q.size() != 0;
        pop_m  = bus.issue_signal && has && !bus.wrong_predicted;
        redir  = pop_m && (bus.next_pc != buf_q[0] + 32'd4);
        cancel = bus.wrong_predicted || redir;
        tgt    = bus.wrong_predicted ? bus.correct_pc : bus.next_pc;
        if (prev_req && bus.icache_ack) begin
          if (!cancel && !stale) begin
            check("room_on_push", 32'(buf_q.size() < QD || pop_m), 32'd1);
            buf_q.push_back(fetch_ptr);
            fetch_ptr = fetch_ptr + 32'd4;
          end
          stale = 1'b0;
          acked = 1'b1;
        end else if (prev_req && cancel) begin
          stale = 1'b1;
        end
        if (pop_m) begin
          void'(buf_q.pop_front());
          pops++;
        end
        if (cancel) begin
          buf_q.delete();
          fetch_ptr = tgt;
        end
      end
      check("dec_valid", 32'(bus.dec_valid), 32'(buf_q.size() != 0));
      check("start_decoder", 32'(bus.start_decoder),
            32'((buf_q.size() != 0) && !bus.wrong_predicted));
      if (buf_q.size() != 0) begin
        check("dec_inst_addr", bus.dec_inst_addr, buf_q[0]);
        check("dec_inst", bus.dec_inst, word_of(buf_q[0]));
      end
      if (acked) check("req_drop", 32'(bus.icache_req), 32'd0);
      if (bus.icache_req && !prev_req) begin
        check("req_addr", bus.icache_addr, fetch_ptr);
        check("req_room", 32'(buf_q.size() < QD), 32'd1);
      end
      if (bus.icache_req && prev_req) begin
        check("addr_stable", bus.icache_addr, prev_addr);
      end
      prev_req  = bus.icache_req;
      prev_addr = bus.icache_addr;
    end
  end

  // One cycle of stimulus: i-cache responder plus decoder/ROB inputs.
  task automatic cycle(input bit iss, input bit jmp, input bit wp,
                       input logic [31:0] cpc, input bit rdy_v,
                       input int dly, input bit force_ack);
    @(negedge clk);
    if (bus.icache_ack && rdy) begin
      bus.icache_ack = 1'b0;
      ack_dly = $urandom_range(0, dly);
    end
    if (bus.icache_req && !bus.icache_ack) begin
      if (ack_dly == 0 || force_ack) begin
        bus.icache_ack  = 1'b1;
        bus.icache_inst = word_of(bus.icache_addr);
      end else begin
        ack_dly--;
      end
    end
    rdy = rdy_v;
    bus.issue_signal = iss;
    bus.next_pc = (buf_q.size() != 0) ? buf_q[0] + 32'd4 : 32'h0;
    if (jmp) begin
      if ($urandom_range(0, 15) == 0) bus.next_pc = 32'hFFFF_FFF0;
      else bus.next_pc = 32'($urandom_range(0, 255)) << 2;
    end
    bus.wrong_predicted = wp;
    bus.correct_pc = cpc;
  endtask

  logic [31:0] saved;

  initial begin
    bus.icache_ack      = 1'b0;
    bus.icache_inst     = 32'h0;
    bus.issue_signal    = 1'b0;
    bus.next_pc         = 32'h0;
    bus.wrong_predicted = 1'b0;
    bus.correct_pc      = 32'h0;
    #1;
    check("rst_req", 32'(bus.icache_req), 32'd0);
    check("rst_valid", 32'(bus.dec_valid), 32'd0);
    check("rst_start", 32'(bus.start_decoder), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Straight-line fetch with immediate acks and issue every cycle
    repeat (40) cycle(1, 0, 0, 0, 1, 0, 0);

    // Flush arriving together with the ack of an outstanding request
    for (int i = 0; i < 50 && !(bus.icache_req && !bus.icache_ack); i++)
      cycle(1, 0, 0, 0, 1, 3, 0);
    check("flush_setup", 32'(bus.icache_req), 32'd1);
    cycle(0, 0, 1, 32'h40, 1, 3, 1);
    repeat (12) cycle(1, 0, 0, 0, 1, 1, 0);

    // Redirects while requests are in flight
    repeat (60) cycle(1, ($urandom_range(0, 3) == 0), 0, 0, 1, 2, 0);

    // Backpressure: decoder stops issuing
    repeat (24) cycle(0, 0, 0, 0, 1, 1, 0);
    @(posedge clk);
    #2;
    check("bp_req", 32'(bus.icache_req), 32'd0);
    check("bp_valid", 32'(bus.dec_valid), 32'd1);

    // rdy_in low with an issue pending
    saved = bus.dec_inst_addr;
    repeat (3) cycle(1, 0, 0, 0, 0, 1, 0);
    @(posedge clk);
    #2;
    check("stall_head", bus.dec_inst_addr, buf_q.size() != 0 ? buf_q[0] : 32'hDEAD_BEEF);
    check("stall_head_held", 32'(bus.dec_inst_addr == saved), 32'd1);
    repeat (10) cycle(1, 0, 0, 0, 1, 1, 0);

    // Asynchronous reset while a request is outstanding
    ack_dly = 3;
    for (int i = 0; i < 50 && !(bus.icache_req && !bus.icache_ack); i++)
      cycle(1, 0, 0, 0, 1, 3, 0);
    check("reset_setup", 32'(bus.icache_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_req", 32'(bus.icache_req), 32'd0);
    check("async_addr", bus.icache_addr, 32'h0);
    check("async_valid", 32'(bus.dec_valid), 32'd0);
    check("async_start", 32'(bus.start_decoder), 32'd0);
    bus.icache_ack      = 1'b0;
    bus.issue_signal    = 1'b0;
    bus.wrong_predicted = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    ack_dly = 0;
    for (int i = 0; i < 20 && !bus.icache_req; i++)
      cycle(0, 0, 0, 0, 1, 0, 0);
    check("post_reset_req", 32'(bus.icache_req), 32'd1);
    check("post_reset_addr", bus.icache_addr, 32'h0);

    // Random mix of everything
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 29) == 0),
            32'($urandom_range(0, 255)) << 2,
            ($urandom_range(0, 9) != 0),
            2, 0);
    end
    repeat (2) @(negedge clk);
    check("liveness", 32'(pops > 200), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
